// File: rtl/spike_packetizer.sv
// Groups a word-serial stream into 3-word routed packets and delivers each one
// over a four-phase bundled-data req/ack channel to the asynchronous mesh.
module spike_packetizer #(
   parameter int FILTER_WIDTH = 8,
   parameter int WIDTH        = 9 + 3 * FILTER_WIDTH,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [FILTER_WIDTH-1:0] in_data,
   input  logic                    in_kind,
   input  logic [1:0]              in_dest,
   input  logic                    in_last,
   output logic                    out_req,
   input  logic                    out_ack,
   output logic [WIDTH-1:0]        out_data,
   output logic                    busy,
   output logic [CNT_WIDTH-1:0]    pkt_count
);

   typedef enum logic [1:0] {COLLECT, REQ, REL} state_t;

   state_t                  state;
   logic [1:0]              cnt;
   logic [FILTER_WIDTH-1:0] slot0;
   logic [FILTER_WIDTH-1:0] slot1;
   logic                    kind_r;
   logic [1:0]              dest_r;
   logic                    ack_m;
   logic                    ack_s;

   logic                    kind_sel;
   logic [1:0]              dest_sel;
   logic [2:0]              hop;
   logic [FILTER_WIDTH-1:0] w0;
   logic [FILTER_WIDTH-1:0] w1;
   logic [FILTER_WIDTH-1:0] w2;
   logic [WIDTH-1:0]        pkt_next;

   // Returns {Y_HOP, X_HOP} for a destination PE.
   function automatic logic [2:0] route(input logic [1:0] dest);
      case (dest)
         2'd0:    route = 3'b1_10;
         2'd1:    route = 3'b1_00;
         2'd2:    route = 3'b0_11;
         default: route = 3'b0_10;
      endcase
   endfunction

   // The closing word is merged straight from the input; slots past it read as zero.
   always_comb begin
      kind_sel = (cnt == 2'd0) ? in_kind : kind_r;
      dest_sel = (cnt == 2'd0) ? in_dest : dest_r;
      hop      = route(dest_sel);
      w0       = (cnt == 2'd0) ? in_data : slot0;
      w1       = (cnt == 2'd1) ? in_data : ((cnt == 2'd2) ? slot1 : '0);
      w2       = (cnt == 2'd2) ? in_data : '0;
      pkt_next = {w2, w1, w0, in_last, kind_sel, dest_sel, hop[2], hop[1:0], 2'b11};
   end

   assign in_ready = (state == COLLECT) && !rst;
   assign busy     = (state != COLLECT) || (cnt != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         cnt       <= 2'd0;
         slot0     <= '0;
         slot1     <= '0;
         kind_r    <= 1'b0;
         dest_r    <= 2'd0;
         ack_m     <= 1'b0;
         ack_s     <= 1'b0;
         out_req   <= 1'b0;
         out_data  <= '0;
         pkt_count <= '0;
      end else begin
         ack_m <= out_ack;
         ack_s <= ack_m;
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  if (cnt == 2'd2 || in_last) begin
                     out_data <= pkt_next;
                     cnt      <= 2'd0;
                     state    <= REQ;
                  end else begin
                     if (cnt == 2'd0) begin
                        slot0  <= in_data;
                        kind_r <= in_kind;
                        dest_r <= in_dest;
                     end else begin
                        slot1 <= in_data;
                     end
                     cnt <= cnt + 2'd1;
                  end
               end
            end
            // Ack is only honoured once req is actually visible, so a stale ack_s cannot skip the request.
            REQ: begin
               if (out_req && ack_s) begin
                  out_req <= 1'b0;
                  state   <= REL;
               end else begin
                  out_req <= 1'b1;
               end
            end
            REL: begin
               if (!ack_s) begin
                  pkt_count <= pkt_count + 1'b1;
                  state     <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer; pkt_count is narrowed to 2 bits so the wrap is reachable.
module tb_spike_packetizer;

   localparam int FW = 8;
   localparam int W  = 9 + 3 * FW;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [FW-1:0] in_data = '0;
   logic          in_kind = 1'b0;
   logic [1:0]    in_dest = 2'd0;
   logic          in_last = 1'b0;
   logic          out_req;
   logic          out_ack = 1'b0;
   logic [W-1:0]  out_data;
   logic          busy;
   logic [CW-1:0] pkt_count;

   int total = 0;
   int bad   = 0;
   logic [CW-1:0] exp_cnt = '0;

   spike_packetizer #(.FILTER_WIDTH(FW), .WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_kind(in_kind), .in_dest(in_dest), .in_last(in_last),
      .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
      .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // Presents one word and holds it until accepted; returns 1ns after the accepting edge.
   task automatic send_word(input logic [FW-1:0] d, input logic k, input logic [1:0] dst,
                            input logic l, output bit ok);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_kind = k; in_dest = dst; in_last = l;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Plays the async side: ack after req rises, release after req drops, then wait for in_ready.
   task automatic handshake(output bit ok);
      int n;
      ok = 1'b1;
      n = 0;
      while (!out_req && n < 10) begin @(negedge clk); n++; end
      if (!out_req) ok = 1'b0;
      @(negedge clk); out_ack = 1'b1;
      n = 0;
      while (out_req && n < 10) begin @(negedge clk); n++; end
      if (out_req) ok = 1'b0;
      out_ack = 1'b0;
      n = 0;
      while (!in_ready && n < 10) begin @(negedge clk); n++; end
      if (!in_ready) ok = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", out_req); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (pkt_count !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", pkt_count); end
      @(negedge clk); rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst got=%b want=1", in_ready); end
   endtask

   task automatic test_full_packet;
      logic [W-1:0] exp;
      bit ok0, ok1, ok2;
      int n;
      exp = {8'h33, 8'h22, 8'h11, 9'h11B};
      send_word(8'h11, 1'b0, 2'd0, 1'b0, ok0);
      send_word(8'h22, 1'b0, 2'd0, 1'b0, ok1);
      send_word(8'h33, 1'b0, 2'd0, 1'b1, ok2);
      total++; if (!(ok0 && ok1 && ok2)) begin bad++; $display("FAIL full_accept got=%b%b%b want=111", ok0, ok1, ok2); end
      total++; if (out_data !== exp) begin bad++; $display("FAIL full_data got=%h want=%h", out_data, exp); end
      total++; if (out_req !== 1'b0) begin bad++; $display("FAIL full_req_early got=%b want=0", out_req); end
      @(posedge clk); #1;
      total++; if (out_req !== 1'b1) begin bad++; $display("FAIL full_req_rise got=%b want=1", out_req); end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_req !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d req=%b data=%h ready=%b want req=1 data=%h ready=0", i, out_req, out_data, in_ready, exp);
         end
      end
      @(negedge clk); out_ack = 1'b1;
      n = 0;
      while (out_req && n < 10) begin @(negedge clk); n++; end
      total++; if (out_req !== 1'b0) begin bad++; $display("FAIL req_fall got=%b want=0", out_req); end
      total++; if (out_data !== exp || in_ready !== 1'b0) begin bad++; $display("FAIL rel_hold data=%h ready=%b want data=%h ready=0", out_data, in_ready, exp); end
      out_ack = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 10);
      total++; if (n !== 3 || in_ready !== 1'b1) begin bad++; $display("FAIL ready_return cycles=%0d ready=%b want cycles=3 ready=1", n, in_ready); end
      exp_cnt++;
      total++; if (pkt_count !== exp_cnt) begin bad++; $display("FAIL full_cnt got=%0d want=%0d", pkt_count, exp_cnt); end
      total++; if (out_data !== exp) begin bad++; $display("FAIL idle_data got=%h want=%h", out_data, exp); end
   endtask

   task automatic test_one_word;
      logic [W-1:0] exp;
      bit ok, hs;
      exp = {8'h00, 8'h00, 8'hAB, 9'h1CF};
      send_word(8'hAB, 1'b1, 2'd2, 1'b1, ok);
      total++; if (!ok || out_data !== exp) begin bad++; $display("FAIL one_word got=%h want=%h", out_data, exp); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL one_busy got=%b want=1", busy); end
      handshake(hs);
      exp_cnt++;
      total++; if (!hs || pkt_count !== exp_cnt) begin bad++; $display("FAIL one_cnt got=%0d hs=%b want=%0d", pkt_count, hs, exp_cnt); end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] exp1, exp2;
      bit ok0, ok1, ok2, hs;
      exp1 = {8'h03, 8'h02, 8'h01, 9'h06B};
      exp2 = {8'h00, 8'h05, 8'h04, 9'h1B3};
      send_word(8'h01, 1'b0, 2'd3, 1'b0, ok0);
      total++; if (busy !== 1'b1 || out_req !== 1'b0) begin bad++; $display("FAIL held_busy busy=%b req=%b want busy=1 req=0", busy, out_req); end
      send_word(8'h02, 1'b1, 2'd0, 1'b0, ok1);
      send_word(8'h03, 1'b1, 2'd0, 1'b0, ok2);
      total++; if (!(ok0 && ok1 && ok2) || out_data !== exp1) begin bad++; $display("FAIL b2b_first got=%h want=%h", out_data, exp1); end
      in_valid = 1'b1; in_data = 8'h04; in_kind = 1'b1; in_dest = 2'd1; in_last = 1'b0;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL req_blocks got=%b want=0", in_ready); end
      handshake(hs);
      exp_cnt++;
      total++; if (!hs || pkt_count !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d hs=%b want=%0d", pkt_count, hs, exp_cnt); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (busy !== 1'b1 || out_data !== exp1) begin bad++; $display("FAIL pending busy=%b data=%h want busy=1 data=%h", busy, out_data, exp1); end
      send_word(8'h05, 1'b0, 2'd0, 1'b1, ok0);
      total++; if (!ok0 || out_data !== exp2) begin bad++; $display("FAIL b2b_second got=%h want=%h", out_data, exp2); end
      handshake(hs);
      exp_cnt++;
      total++; if (!hs || pkt_count !== exp_cnt) begin bad++; $display("FAIL b2b_cnt2 got=%0d hs=%b want=%0d", pkt_count, hs, exp_cnt); end
   endtask

   task automatic test_ack_glitch;
      @(negedge clk); out_ack = 1'b1;
      @(negedge clk); out_ack = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (out_req !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || pkt_count !== exp_cnt) begin
         bad++;
         $display("FAIL ack_glitch req=%b ready=%b busy=%b cnt=%0d want 0 1 0 %0d", out_req, in_ready, busy, pkt_count, exp_cnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] exp;
      bit ok0, ok1, hs;
      exp = {8'h00, 8'h3C, 8'hC3, 9'h1EB};
      send_word(8'h5A, 1'b0, 2'd1, 1'b1, ok0);
      @(posedge clk); #1;
      total++; if (out_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%b want=1", out_req); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_req !== 1'b0 || out_data !== '0 || pkt_count !== '0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst req=%b data=%h cnt=%0d ready=%b want 0 0 0 0", out_req, out_data, pkt_count, in_ready);
      end
      @(negedge clk); rst = 1'b0;
      exp_cnt = '0;
      send_word(8'hC3, 1'b1, 2'd3, 1'b0, ok0);
      send_word(8'h3C, 1'b0, 2'd0, 1'b1, ok1);
      total++; if (!(ok0 && ok1) || out_data !== exp) begin bad++; $display("FAIL post_rst got=%h want=%h", out_data, exp); end
      handshake(hs);
      exp_cnt++;
      total++; if (!hs || pkt_count !== exp_cnt) begin bad++; $display("FAIL post_rst_cnt got=%0d want=%0d", pkt_count, exp_cnt); end
   endtask

   task automatic test_wrap;
      logic [W-1:0] exp;
      bit ok, hs;
      for (int i = 0; i < 3; i++) begin
         exp = {8'h00, 8'h00, 8'(8'h70 + i), 9'h11B};
         send_word(8'(8'h70 + i), 1'b0, 2'd0, 1'b1, ok);
         total++; if (!ok || out_data !== exp) begin bad++; $display("FAIL wrap_data_%0d got=%h want=%h", i, out_data, exp); end
         handshake(hs);
         exp_cnt++;
         total++; if (!hs || pkt_count !== exp_cnt) begin bad++; $display("FAIL wrap_cnt_%0d got=%0d want=%0d", i, pkt_count, exp_cnt); end
      end
      total++; if (pkt_count !== 2'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", pkt_count); end
   endtask

   initial begin
      test_reset();
      test_full_packet();
      test_one_word();
      test_back_to_back();
      test_ack_glitch();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
